// File: rtl/xpmwrap_sdpram_stream_pkg.sv
// ----------------------------------------------------------------------------
// xpmwrap_pkg
// Shared types and helpers for the streaming simple dual-port RAM wrapper.
//   state_e      : sequencer state (INIT clears the array, RUN serves clients)
//   S_INIT/S_RUN : the same encodings as plain vector constants
//   num_bytes    : number of byte-enable lanes for a word/lane width pair
//   skid_depth   : response buffer depth needed to cover the read latency
//   latency_legal: supported RAM read latencies
//   width_legal  : word width must be a whole number of lanes
// ----------------------------------------------------------------------------
package xpmwrap_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    function automatic int num_bytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // READ_LATENCY words can be in the RAM pipeline while the FIFO head is
    // stalled; two extra entries keep one-per-cycle streaming with the
    // registered-only request-ready decision.
    function automatic int skid_depth(input int read_latency);
        return read_latency + 2;
    endfunction

    function automatic bit latency_legal(input int read_latency);
        return (read_latency >= 1) && (read_latency <= 4);
    endfunction

    function automatic bit width_legal(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

endpackage

// File: rtl/xpmwrap_sdpram_stream_if.sv
// ----------------------------------------------------------------------------
// xpmwrap_sdpram_stream_if
// Client-side bundle of the streaming RAM: write port, read-request port,
// read-response port and the clear-complete flag.
//
// Handshake rule for every channel (wr, rd_req, rd_rsp): a transfer happens
// on a rising clock edge where valid && ready are both high. The source holds
// valid and its payload stable until the transfer; ready may change freely
// and never depends combinationally on the same channel's valid.
//
// Modports:
//   master : the client (drives requests, consumes responses)
//   slave  : the RAM wrapper
// ----------------------------------------------------------------------------
interface xpmwrap_sdpram_stream_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BYTES  = 4
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [NUM_BYTES-1:0]  wr_be;

    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [ADDR_WIDTH-1:0] rd_req_addr;

    logic                  rd_rsp_valid;
    logic                  rd_rsp_ready;
    logic [DATA_WIDTH-1:0] rd_rsp_data;

    logic                  init_done;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_be,
        output rd_req_valid, rd_req_addr, rd_rsp_ready,
        input  wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, init_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_be,
        input  rd_req_valid, rd_req_addr, rd_rsp_ready,
        output wr_ready, rd_req_ready, rd_rsp_valid, rd_rsp_data, init_done
    );

endinterface

// File: rtl/xpmwrap_sdpram_stream_core.sv
// ----------------------------------------------------------------------------
// xpmwrap_sdpram_core
// Common-clock simple dual-port block RAM, read-first, byte-write lanes of
// BYTE_WIDTH bits, READ_LATENCY-cycle registered read path. Behaviour matches
// xpm_memory_sdpram in that configuration with rstb tied low: the array and
// the read pipeline are never reset.
// A write-side mux lets the clear sequencer override the user write port.
//
// Ports:
//   i_clk        clock
//   i_init_en    clear sequencer owns port A (zero data, all lanes enabled)
//   i_init_addr  clear address
//   i_wr_en      user write enable (ignored while i_init_en)
//   i_wr_addr    user write address
//   i_wr_data    user write data
//   i_wr_be      user byte enables
//   i_rd_en      read enable (port B)
//   i_rd_addr    read address
//   o_rd_data    read data, READ_LATENCY cycles after i_rd_en
// ----------------------------------------------------------------------------
module xpmwrap_sdpram_core
    import xpmwrap_pkg::*;
#(
    parameter int ADDR_WIDTH   = 6,
    parameter int DATA_WIDTH   = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int NUM_BYTES    = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                  i_clk,
    input  logic                  i_init_en,
    input  logic [ADDR_WIDTH-1:0] i_init_addr,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [NUM_BYTES-1:0]  i_wr_be,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem     [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_pipe [READ_LATENCY];

    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NUM_BYTES-1:0]  w_be;

    assign w_we   = i_init_en | i_wr_en;
    assign w_addr = i_init_en ? i_init_addr : i_wr_addr;
    assign w_data = i_init_en ? '0 : i_wr_data;
    assign w_be   = i_init_en ? '1 : i_wr_be;

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read in a separate process: the non-blocking write above lands after
    // this sample, so a same-address collision returns the old word.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_pipe[0] <= r_mem[i_rd_addr];
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
    end

    assign o_rd_data = r_rd_pipe[READ_LATENCY-1];

endmodule

// File: rtl/xpmwrap_sdpram_stream.sv
// ----------------------------------------------------------------------------
// xpmwrap_sdpram_stream
// Streaming simple dual-port RAM: valid/ready write and read ports, byte
// enables, zero-fill after reset, and a credit-tracked response FIFO that
// hides the RAM read latency from the client.
//
// Ports:
//   clka         clock
//   rsta         asynchronous active-high reset (control state only)
//   s_bus        client bundle (slave side), see xpmwrap_sdpram_stream_if
//   o_dbg_state  sequencer state (S_INIT / S_RUN)
// ----------------------------------------------------------------------------
module xpmwrap_sdpram_stream
    import xpmwrap_pkg::*;
#(
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 32,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                  clka,
    input  logic                  rsta,
    xpmwrap_sdpram_stream_if.slave s_bus,
    output logic [0:0]            o_dbg_state
);

    localparam int NUM_BYTES  = num_bytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int SKID_DEPTH = skid_depth(READ_LATENCY);
    localparam int CW         = $clog2(SKID_DEPTH + 1);
    localparam int PW         = $clog2(SKID_DEPTH);

    localparam logic [CW-1:0] SKID_C    = CW'(SKID_DEPTH);
    localparam logic [PW-1:0] PTR_LAST  = PW'(SKID_DEPTH - 1);
    localparam logic [0:0]    RST_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_RUN;

    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("xpmwrap_sdpram_stream: READ_LATENCY must be 1..4");
    end
    if (!width_legal(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("xpmwrap_sdpram_stream: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    // ---------------- clear sequencer ----------------
    logic [0:0]          r_state;
    logic [ADDR_WIDTH:0] r_init_addr;
    logic [ADDR_WIDTH:0] w_init_next;
    logic                w_init_en;
    logic                w_run;

    assign w_init_next = r_init_addr + (ADDR_WIDTH+1)'(1);
    assign w_init_en   = (r_state == S_INIT);
    assign w_run       = (r_state == S_RUN);

    // The extra counter bit flags the terminal count: the edge that writes
    // the last address also moves the sequencer to RUN.
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_state     <= RST_STATE;
            r_init_addr <= '0;
        end else if (r_state == S_INIT) begin
            r_init_addr <= w_init_next;
            if (w_init_next[ADDR_WIDTH]) begin
                r_state <= S_RUN;
            end
        end
    end

    // ---------------- handshakes ----------------
    logic [CW-1:0] r_credit;
    logic          w_req_ready;
    logic          w_req_acc;
    logic          w_wr_acc;
    logic          w_pop;
    logic          w_push;

    // Depends only on registered state, never on rd_rsp_ready.
    assign w_req_ready = w_run && (r_credit < SKID_C);
    assign w_req_acc   = s_bus.rd_req_valid && w_req_ready;
    assign w_wr_acc    = s_bus.wr_valid && w_run;

    // ---------------- RAM ----------------
    logic [DATA_WIDTH-1:0] w_ram_rd_data;

    xpmwrap_sdpram_core #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .BYTE_WIDTH   (BYTE_WIDTH),
        .NUM_BYTES    (NUM_BYTES),
        .READ_LATENCY (READ_LATENCY)
    ) u_core (
        .i_clk       (clka),
        .i_init_en   (w_init_en),
        .i_init_addr (r_init_addr[ADDR_WIDTH-1:0]),
        .i_wr_en     (w_wr_acc),
        .i_wr_addr   (s_bus.wr_addr),
        .i_wr_data   (s_bus.wr_data),
        .i_wr_be     (s_bus.wr_be),
        .i_rd_en     (w_req_acc),
        .i_rd_addr   (s_bus.rd_req_addr),
        .o_rd_data   (w_ram_rd_data)
    );

    // Valid tags shadow the unreset RAM read pipeline so that words in
    // flight at reset are dropped instead of pushed.
    logic [READ_LATENCY-1:0] r_vpipe;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_req_acc;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // ---------------- response FIFO ----------------
    logic [DATA_WIDTH-1:0] r_fifo [SKID_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    assign w_push = r_vpipe[READ_LATENCY-1];
    assign w_pop  = (r_count != '0) && s_bus.rd_rsp_ready;

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                r_fifo[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_ram_rd_data;
                r_wr_ptr         <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ---------------- credit ----------------
    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_credit <= '0;
        end else begin
            case ({w_req_acc, w_pop})
                2'b10:   r_credit <= r_credit + CW'(1);
                2'b01:   r_credit <= r_credit - CW'(1);
                default: r_credit <= r_credit;
            endcase
        end
    end

    a_fifo_no_overflow : assert property (@(posedge clka) disable iff (rsta)
        (w_push && !w_pop) |-> (r_count < SKID_C));

    a_credit_in_range : assert property (@(posedge clka) disable iff (rsta)
        r_credit <= SKID_C);

    // ---------------- outputs ----------------
    assign s_bus.wr_ready     = w_run;
    assign s_bus.rd_req_ready = w_req_ready;
    assign s_bus.rd_rsp_valid = (r_count != '0);
    assign s_bus.rd_rsp_data  = r_fifo[r_rd_ptr];
    assign s_bus.init_done    = w_run;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_xpmwrap_sdpram_stream.sv
// ----------------------------------------------------------------------------
// tb_xpmwrap_sdpram_stream
// Directed and random checks of the streaming RAM against a word-array model
// with an expected-response queue.
// ----------------------------------------------------------------------------
module tb_xpmwrap_sdpram_stream;
    import xpmwrap_pkg::*;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int NB = DW / BW;
    localparam int L  = 2;
    localparam int DEPTH = 2 ** AW;

    // ---------------- clock / reset ----------------
    logic clka;
    logic rsta;
    logic [0:0] dbg_state;

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    xpmwrap_sdpram_stream_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTES(NB)) bus ();

    xpmwrap_sdpram_stream #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .BYTE_WIDTH    (BW),
        .READ_LATENCY  (L),
        .INIT_ON_RESET (1)
    ) dut (
        .clka        (clka),
        .rsta        (rsta),
        .s_bus       (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rsp_log[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_pop    = 0;

    task automatic check32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_q.delete();
    endtask

    // Called at a falling edge with inputs set: evaluates the transfers the
    // next rising edge will perform, then advances one cycle.
    task automatic tick();
        logic [DW-1:0] w;
        if (bus.rd_rsp_valid && bus.rd_rsp_ready) begin
            n_pop++;
            rsp_log.push_back(bus.rd_rsp_data);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL rsp_spurious: observed response %h, expected none", bus.rd_rsp_data);
            end else begin
                check32("rsp_data", bus.rd_rsp_data, exp_q.pop_front());
            end
        end
        if (bus.rd_req_valid && bus.rd_req_ready) begin
            exp_q.push_back(model_mem[bus.rd_req_addr]);
            n_acc++;
        end
        if (bus.wr_valid && bus.wr_ready) begin
            w = model_mem[bus.wr_addr];
            for (int i = 0; i < NB; i++)
                if (bus.wr_be[i]) w[i*BW +: BW] = bus.wr_data[i*BW +: BW];
            model_mem[bus.wr_addr] = w;
        end
        @(posedge clka);
        @(negedge clka);
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.wr_valid     = 1'b0;
        bus.wr_addr      = '0;
        bus.wr_data      = '0;
        bus.wr_be        = '0;
        bus.rd_req_valid = 1'b0;
        bus.rd_req_addr  = '0;
        bus.rd_rsp_ready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        bus.wr_be    = be;
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.rd_rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.rd_rsp_valid) && guard < 64) begin
            tick();
            guard++;
        end
        check32("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic read_latency(input logic [AW-1:0] a);
        int lat;
        bus.rd_rsp_ready = 1'b1;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = a;
        check32("rd_req_ready_idle", 32'(bus.rd_req_ready), 32'd1);
        tick();
        bus.rd_req_valid = 1'b0;
        lat = 1;
        while (!bus.rd_rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check32("rsp_latency", 32'(lat), 32'(L + 1));
        drain();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc0, pop0, gaps, guard;
        bit seen;

        rsta = 1'b1;
        idle_inputs();
        model_clear();
        repeat (3) @(negedge clka);

        check32("rst_wr_ready",     32'(bus.wr_ready),     32'd0);
        check32("rst_rd_req_ready", 32'(bus.rd_req_ready), 32'd0);
        check32("rst_rsp_valid",    32'(bus.rd_rsp_valid), 32'd0);
        check32("rst_rsp_data",     bus.rd_rsp_data,       32'd0);
        check32("rst_init_done",    32'(bus.init_done),    32'd0);
        check32("rst_state",        32'(dbg_state),        32'(S_INIT));

        // Clear sequence: init_done exactly DEPTH edges after release.
        rsta = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) begin
                check32("init_done_early", 32'(bus.init_done),    32'd0);
                check32("init_rd_blocked", 32'(bus.rd_req_ready), 32'd0);
                check32("init_wr_blocked", 32'(bus.wr_ready),     32'd0);
            end
        end
        check32("init_done",     32'(bus.init_done), 32'd1);
        check32("run_wr_ready",  32'(bus.wr_ready),  32'd1);
        check32("run_state",     32'(dbg_state),     32'(S_RUN));

        read_latency(6'd0);
        read_latency(6'd31);
        read_latency(6'd63);

        // Byte-enable merge.
        do_write(6'd5, 32'hAABBCCDD, 4'hF);
        do_write(6'd5, 32'h11223344, 4'b0101);
        do_write(6'd5, 32'hFFFFFFFF, 4'b0000);
        rsp_log.delete();
        read_latency(6'd5);
        check32("byte_merge", rsp_log[0], 32'hAA22CC44);

        // Backpressure: SKID_DEPTH accepts, then hold.
        for (int i = 0; i < 8; i++) do_write(6'(16 + i), 32'hC0DE0000 + 32'(i), 4'hF);
        bus.rd_rsp_ready = 1'b0;
        acc0 = n_acc;
        pop0 = n_pop;
        for (int i = 0; i < 8; i++) begin
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr  = 6'(16 + i);
            tick();
        end
        bus.rd_req_valid = 1'b0;
        check32("bp_accepts",      32'(n_acc - acc0),     32'(L + 2));
        check32("bp_req_blocked",  32'(bus.rd_req_ready), 32'd0);
        check32("bp_rsp_valid",    32'(bus.rd_rsp_valid), 32'd1);
        check32("bp_head_data",    bus.rd_rsp_data,       exp_q[0]);
        tick();
        tick();
        check32("bp_head_stable",  bus.rd_rsp_data,       exp_q[0]);
        bus.rd_rsp_ready = 1'b1;
        check32("bp_req_pre_rel",  32'(bus.rd_req_ready), 32'd0);
        tick();
        check32("bp_req_resumed",  32'(bus.rd_req_ready), 32'd1);
        drain();
        check32("bp_pops",         32'(n_pop - pop0),     32'(L + 2));

        // Throughput: back-to-back reads, no bubbles once data flows.
        acc0 = n_acc;
        gaps = 0;
        seen = 1'b0;
        bus.rd_rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr  = 6'($urandom_range(0, DEPTH - 1));
            if (bus.rd_rsp_valid) seen = 1'b1;
            else if (seen) gaps++;
            tick();
        end
        bus.rd_req_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            if (!bus.rd_rsp_valid) gaps++;
            tick();
            guard++;
        end
        check32("tp_accepts", 32'(n_acc - acc0), 32'd100);
        check32("tp_bubbles", 32'(gaps),         32'd0);
        drain();

        // Read/write collision is read-first.
        do_write(6'd9, 32'h1, 4'hF);
        rsp_log.delete();
        bus.wr_valid     = 1'b1;
        bus.wr_addr      = 6'd9;
        bus.wr_data      = 32'h2;
        bus.wr_be        = 4'hF;
        bus.rd_req_valid = 1'b1;
        bus.rd_req_addr  = 6'd9;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        bus.rd_req_valid = 1'b0;
        drain();
        check32("collision_old", rsp_log[0], 32'h1);
        check32("collision_new", rsp_log[1], 32'h2);

        // Mid-operation reset with responses pending.
        bus.rd_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.rd_req_valid = 1'b1;
            bus.rd_req_addr  = 6'd9;
            tick();
        end
        bus.rd_req_valid = 1'b0;
        repeat (4) tick();
        check32("pre_rst_valid", 32'(bus.rd_rsp_valid), 32'd1);
        #2 rsta = 1'b1;
        #1;
        check32("async_rsp_drop",  32'(bus.rd_rsp_valid), 32'd0);
        check32("async_init_drop", 32'(bus.init_done),    32'd0);
        @(negedge clka);
        @(negedge clka);
        model_clear();
        rsta = 1'b0;
        bus.rd_rsp_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            if (i == DEPTH - 1) check32("reinit_early", 32'(bus.init_done), 32'd0);
        end
        check32("reinit_done", 32'(bus.init_done), 32'd1);
        rsp_log.delete();
        read_latency(6'd9);
        check32("reinit_addr9", rsp_log[0], 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            bus.wr_valid     = ($urandom_range(0, 2) == 0);
            bus.wr_addr      = 6'($urandom_range(0, DEPTH - 1));
            bus.wr_data      = $urandom;
            bus.wr_be        = 4'($urandom_range(0, 15));
            bus.rd_req_valid = ($urandom_range(0, 1) == 1);
            bus.rd_req_addr  = 6'($urandom_range(0, DEPTH - 1));
            bus.rd_rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        idle_inputs();
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xpmwrap_sdpram_stream.md
Name: xpmwrap_sdpram_stream

Overview:
Single-clock simple dual-port RAM with valid/ready streaming on both ports, byte-enable writes and a power-on clear sequencer. Wraps an XPM simple dual-port block RAM in common-clock mode. A credit-tracked response buffer absorbs downstream backpressure over the RAM's fixed read latency, so clients never need to know that latency. Serves as the generic buffer/lookup store for streaming datapaths.

Parameters:
ADDR_WIDTH, 6, word address width; depth = 2**ADDR_WIDTH
DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
READ_LATENCY, 2, RAM read latency, legal range 1..4
INIT_ON_RESET, 1, 1 = zero-fill the whole array after reset; 0 = go straight to RUN

Ports:
clka  in  1  clock
rsta  in  1  reset, asynchronous, active-high
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  NUM_BYTES  byte enables; bit i writes bits [i*BYTE_WIDTH +: BYTE_WIDTH]
rd_req_valid  in  1  read request
rd_req_ready  out  1  read request accepted on valid && ready
rd_req_addr  in  ADDR_WIDTH  read address
rd_rsp_valid  out  1  read data available
rd_rsp_ready  in  1  consumer accepts read data
rd_rsp_data  out  DATA_WIDTH  read data, in request order
init_done  out  1  high once clear sequence is complete (held until reset)

Behaviour:
- Clock and reset: one clock, clka. Reset rsta is asynchronous and active-high.
- Reset values: wr_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, init_done=0. Response FIFO is empty, credit count is 0, and the FSM is in INIT (or RUN if INIT_ON_RESET=0).
- The RAM macro's own rstb is tied low. Async reset acts only on control state and never touches array contents.
- FSM INIT:
  - Writes all-zero words, all bytes enabled, to addresses 0 .. 2**ADDR_WIDTH-1, one per cycle starting on the first clock after reset release.
  - After the last address, the FSM moves to RUN next cycle. INIT lasts exactly 2**ADDR_WIDTH cycles.
  - wr_ready=0 and rd_req_ready=0 throughout INIT.
- FSM RUN:
  - init_done=1 and wr_ready=1 constantly; writes are never stalled.
  - The FSM has no exit from RUN except reset.
- Write: an accepted write updates the enabled bytes at wr_addr on that clock edge. wr_be=0 is a legal no-op.
- Read request:
  - rd_req_ready = RUN && credit < SKID_DEPTH, where SKID_DEPTH = READ_LATENCY+2.
  - rd_req_ready is a registered-state function only; there is no combinational path from rd_rsp_ready.
- Credit counter:
  - Increments on request accept and decrements on response pop. Both in the same cycle means no change.
  - Credit counts requests in flight in the RAM pipeline plus words held in the FIFO. Range 0..SKID_DEPTH; it must never overflow.
- Response path:
  - RAM data enters the SKID_DEPTH-entry response FIFO exactly READ_LATENCY cycles after accept.
  - The FIFO head drives rd_rsp_valid/rd_rsp_data. Earliest rd_rsp_valid is READ_LATENCY+1 cycles after accept.
  - A pop occurs on rd_rsp_valid && rd_rsp_ready.
  - rd_rsp_data holds stable while valid && !ready.
  - The FIFO can never overflow, by credit construction. An assertion must check this.
- Throughput: with rd_rsp_ready held high, one request per cycle is sustained indefinitely.
- Read/write collision, same address same cycle: the read returns the pre-write data (read-first).
- Reset mid-operation: in-flight reads and buffered responses are discarded. A pending response is not delivered after reset. INIT restarts from address 0 when INIT_ON_RESET=1.
- Width rules: address counter is ADDR_WIDTH+1 bits so the terminal count is detected without wrap. Credit counter is clog2(SKID_DEPTH+1) bits.

Decomposition:
- Package xpmwrap_pkg:
  - state enum {INIT, RUN}
  - function for NUM_BYTES
  - function for SKID_DEPTH
  - READ_LATENCY legality check
- Sub-module xpmwrap_sdpram_core:
  - thin XPM SDPRAM instance, common_clock, block primitive, read_first, byte-write width BYTE_WIDTH, latency READ_LATENCY
  - write-side mux selects init address/zero data/all-ones enable vs. user write
- The response FIFO and credit logic stay in the top module.

Test Plan:
- Clear after reset (AW=6, L=2): release rsta → init_done rises exactly 64 cycles later. Reads of addresses 0, 31 and 63 return 0x00000000, each with rd_rsp_valid 3 cycles after accept.
- Byte write: write 0xAABBCCDD be=4'hF to addr 5, then 0x11223344 be=4'b0101 → read addr 5 returns 0xAA22CC44.
- Backpressure (L=2): hold rd_rsp_ready=0 and issue requests every cycle:
  - exactly 4 are accepted, then rd_req_ready=0 and data stays stable
  - after release, 4 responses arrive in order with none lost
  - requests resume next cycle.
- Throughput: 100 back-to-back reads with rd_rsp_ready=1 → 100 accepts in 100 cycles, responses in order with no bubbles after first valid.
- Collision: addr 9 holds 0x1; write 0x2 and read addr 9 in the same cycle → response 0x1; a subsequent read returns 0x2.
- Mid-operation reset: assert rsta with 3 responses pending → rd_rsp_valid drops immediately (async) and no stale response appears afterwards. INIT reruns for 64 cycles and address 9 then reads 0x0.
